// File: rtl/io_pkg.sv
// Shared types and constants for the memory-mapped UART port.
// No logic; imported by uart_rx and uart_io_unit.
// Holds the TX/RX state encodings and the frame width.
package io_pkg;

    localparam int UART_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [31:0] zext_byte(input logic [UART_BITS-1:0] b);
        return {{(32-UART_BITS){1'b0}}, b};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, start-bit recheck at half bit, mid-bit sampling.
// Latency: rx_vld pulses one clock after the mid-stop-bit sample.
// Backpressure: none; the consumer must take rx_dat on the rx_vld cycle.
module uart_rx
    import io_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [UART_BITS-1:0] rx_dat,
    output logic                 rx_vld
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_BITS - 1);

    logic                 rxd_m;
    logic                 rxd_s;
    logic                 rxd_d;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [UART_BITS-1:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m  <= 1'b1;
            rxd_s  <= 1'b1;
            rxd_d  <= 1'b1;
            state  <= RX_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            rx_dat <= '0;
            rx_vld <= 1'b0;
        end else begin
            rxd_m  <= rxd;
            rxd_s  <= rxd_m;
            rxd_d  <= rxd_s;
            rx_vld <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rxd_d && !rxd_s) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // A line back high at mid start bit was a glitch, not a frame.
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[UART_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rxd_s) begin
                            rx_dat <= shreg;
                            rx_vld <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_io_unit.sv
// Memory-mapped UART port: stores serialise onto txd, loads pop the RX FIFO. UART_OVF_EN adds rx_overflow.
// Latency: load data one clock after the pop; store frame starts the clock after acceptance.
// Backpressure: io_stall holds a load while the FIFO is empty and a store while TX is busy.
module uart_io_unit
    import io_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int FIFO_LOG2        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_re,
    input  logic        io_we,
    input  logic [7:0]  io_wdata,
    output logic [31:0] io_rdata,
    output logic        io_rvalid,
    output logic        io_stall,
    input  logic        rxd,
    output logic        txd
`ifdef UART_OVF_EN
    ,
    output logic        rx_overflow
`endif
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_BITS - 1);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_CNT = DEPTH[FIFO_LOG2:0];

    logic [UART_BITS-1:0] rx_dat;
    logic                 rx_vld;

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .rx_dat (rx_dat),
        .rx_vld (rx_vld)
    );

    logic [UART_BITS-1:0] fifo_mem [DEPTH];
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2:0]   fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_idx;
    logic [UART_BITS-1:0] tx_byte;
    logic                 tx_busy;

    logic store_acc;
    logic load_pop;
    logic push_ok;
    logic push_drop;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign tx_busy    = (tx_state != TX_IDLE);

    // A simultaneous store wins; the load is dropped rather than popped.
    assign store_acc = io_we && !tx_busy;
    assign load_pop  = io_re && !io_we && !fifo_empty;
    assign push_ok   = rx_vld && (!fifo_full || load_pop);
    assign push_drop = rx_vld && fifo_full && !load_pop;
    assign io_stall  = (io_re && fifo_empty) || (io_we && tx_busy);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= rx_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_cnt  <= '0;
            io_rdata  <= '0;
            io_rvalid <= 1'b0;
        end else begin
            io_rvalid <= load_pop;
            if (load_pop) begin
                io_rdata <= zext_byte(fifo_mem[rd_ptr]);
                rd_ptr   <= rd_ptr + 1'b1;
            end
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            case ({push_ok, load_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef UART_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rx_overflow <= 1'b0;
        else if (push_drop) rx_overflow <= 1'b1;
    end
`else
    logic unused_drop;
    assign unused_drop = push_drop;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_byte  <= '0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (store_acc) begin
                        tx_byte  <= io_wdata;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                        txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= TX_DATA;
                        txd      <= tx_byte[0];
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    // tx_byte shifts right so the next bit to send is always at [1].
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        tx_idx <= tx_idx + 1'b1;
                        if (tx_idx == IDX_LAST) begin
                            tx_state <= TX_STOP;
                            txd      <= 1'b1;
                        end else begin
                            tx_byte <= {1'b0, tx_byte[UART_BITS-1:1]};
                            txd     <= tx_byte[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    a_no_re_we: assert property (@(posedge clk) disable iff (rst) !(io_re && io_we));

endmodule

// File: tb/tb_uart_io_unit.sv
// Bench for uart_io_unit with an 8-clock bit period; frames and FIFO contents come from a queue model.
// Build with UART_OVF_EN defined to also check rx_overflow.
module tb_uart_io_unit;

    localparam int HALF  = 4;
    localparam int BITP  = 2 * HALF;
    localparam int LOG2  = 4;
    localparam int DEPTH = 1 << LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_re;
    logic        io_we;
    logic [7:0]  io_wdata;
    logic [31:0] io_rdata;
    logic        io_rvalid;
    logic        io_stall;
    logic        rxd;
    logic        txd;
`ifdef UART_OVF_EN
    logic        rx_overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] model_q [$];
    logic       ovf_exp = 1'b0;

    uart_io_unit #(.CLK_PER_HALF_BIT(HALF), .FIFO_LOG2(LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_re      (io_re),
        .io_we      (io_we),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_rvalid  (io_rvalid),
        .io_stall   (io_stall),
        .rxd        (rxd),
        .txd        (txd)
`ifdef UART_OVF_EN
        ,
        .rx_overflow(rx_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: a frame that ends in a good stop bit enters the FIFO unless it is full.
    task automatic model_push(input logic [7:0] b, input logic stop);
        if (stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else                        ovf_exp = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            rxd = bits[j];
            repeat (BITP - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (BITP - 1) @(negedge clk);
    endtask

    task automatic do_store(input logic [7:0] b, output int stalls);
        int n;
        @(negedge clk);
        io_we    = 1'b1;
        io_wdata = b;
        #1;
        n = 0;
        while (io_stall && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("store_wait_bound", 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
        io_we  = 1'b0;
        stalls = n;
    endtask

    task automatic check_tx_frame(input logic [7:0] b);
        logic [9:0] first_s;
        logic [9:0] last_s;
        logic [9:0] exp;
        exp = {1'b1, b, 1'b0};
        first_s = '0;
        last_s  = '0;
        for (int k = 0; k < 10 * BITP; k++) begin
            @(negedge clk);
            if (k % BITP == 0)        first_s[k / BITP] = txd;
            if (k % BITP == BITP - 1) last_s[k / BITP]  = txd;
        end
        chk("tx_frame_first", 32'(first_s), 32'(exp));
        chk("tx_frame_last", 32'(last_s), 32'(exp));
        @(negedge clk);
        chk("tx_idle_after", 32'(txd), 32'd1);
    endtask

    task automatic do_load(input string tag);
        int n;
        logic [7:0] exp_b;
        exp_b = model_q.pop_front();
        @(negedge clk);
        io_re = 1'b1;
        #1;
        n = 0;
        while (io_stall && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("load_wait_bound", 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
        io_re = 1'b0;
        @(negedge clk);
        chk("load_rvalid", 32'(io_rvalid), 32'd1);
        chk(tag, io_rdata, {24'b0, exp_b});
    endtask

    task automatic check_empty(input string tag);
        @(negedge clk);
        io_re = 1'b1;
        #1;
        chk(tag, 32'(io_stall), 32'd1);
        io_re = 1'b0;
    endtask

    initial begin
        int stalls;
        logic [7:0] b;
        logic stop;

        rst = 1'b1; io_re = 1'b0; io_we = 1'b0; io_wdata = '0; rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rvalid", 32'(io_rvalid), 32'd0);
        chk("rst_rdata", io_rdata, 32'd0);
        chk("rst_stall", 32'(io_stall), 32'd0);
`ifdef UART_OVF_EN
        chk("rst_ovf", 32'(rx_overflow), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Store on idle TX, then a second store two clocks into the frame.
        do_store(8'hA5, stalls);
        chk("store_idle_stall", stalls, 0);
        check_tx_frame(8'hA5);
        do_store(8'h96, stalls);
        repeat (2) @(negedge clk);
        do_store(8'h3C, stalls);
        chk("store_busy_stalls", stalls, 10 * BITP - 2);
        check_tx_frame(8'h3C);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            do_store(b, stalls);
            chk("store_rand_stall", stalls, 0);
            check_tx_frame(b);
        end

        // Load waiting on an empty FIFO while a frame arrives.
        check_empty("load_empty_stall");
        @(negedge clk);
        io_re = 1'b1;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                int n;
                n = 0;
                #1;
                while (io_stall && n < 300) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("load_wait_bound", 32'(n < 300), 32'd1);
                chk("load_stalled_long", 32'(n > 8 * BITP), 32'd1);
                @(posedge clk);
                #1;
                io_re = 1'b0;
                @(negedge clk);
                chk("load_wait_rvalid", 32'(io_rvalid), 32'd1);
                chk("load_wait_rdata", io_rdata, 32'h0000005A);
                @(negedge clk);
                chk("rvalid_pulse", 32'(io_rvalid), 32'd0);
            end
        join
        check_empty("empty_after_wait");

        // Overfill: 17 bytes, only the first 16 survive.
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1);
            model_push(8'(i), 1'b1);
        end
        for (int i = 0; i < DEPTH; i++) do_load("ovf_load_data");
        check_empty("empty_after_drain");
`ifdef UART_OVF_EN
        chk("ovf_flag", 32'(rx_overflow), 32'(ovf_exp));
`endif

        // Framing error and a short glitch push nothing.
        send_frame(8'hC7, 1'b0);
        check_empty("empty_after_frame_err");
        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * BITP) @(negedge clk);
        check_empty("empty_after_glitch");

        // Random frames with occasional bad stop bits.
        for (int i = 0; i < 6; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            model_push(b, stop);
        end
        while (model_q.size() > 0) do_load("rand_load_data");
        check_empty("empty_after_rand");

        // Reset in mid TX frame with a byte waiting in the FIFO.
        send_frame(8'h77, 1'b1);
        do_store(8'h00, stalls);
        repeat (30) @(negedge clk);
        chk("tx_mid_frame", 32'(txd), 32'd0);
        #1;
        io_we = 1'b1;
        rst   = 1'b1;
        #1;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_stall", 32'(io_stall), 32'd0);
        chk("rst_mid_rdata", io_rdata, 32'd0);
        @(negedge clk);
        io_we = 1'b0;
        rst   = 1'b0;
        model_q.delete();
        ovf_exp = 1'b0;
        check_empty("empty_after_rst");
`ifdef UART_OVF_EN
        chk("ovf_after_rst", 32'(rx_overflow), 32'(ovf_exp));
`endif
        do_store(8'hC3, stalls);
        chk("store_after_rst_stall", stalls, 0);
        check_tx_frame(8'hC3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
